// File: rtl/tnn_frame_sequencer_if.sv
// Stream-side bus of the TNN frame sequencer: feature beats in, class results out.
interface tnn_frame_sequencer_if #(
    parameter int FEAT_W = 2
);
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_class;
    logic              m_err;

    // Environment side: produces feature beats and consumes results.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    // Sequencer side: consumes feature beats and produces results.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/tnn_frame_sequencer.sv
// Frame sequencer for a combinational approximate-TNN classifier core.
// Gathers serial 2-bit features into a frame, holds them on the core while it
// settles, samples the class bit and hands it out over valid/ready, counting
// delivered results and positive results with saturating counters.
module tnn_frame_sequencer #(
    parameter int N_FEAT      = 8,
    parameter int FEAT_W      = 2,
    parameter int EVAL_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tnn_frame_sequencer_if.slave     bus,
    output logic [N_FEAT*FEAT_W-1:0] core_feat,
    input  logic                     core_out,
    input  logic                     cnt_clear,
    output logic [CNT_W-1:0]         sample_count,
    output logic [CNT_W-1:0]         pos_count
);

    localparam int              IDX_W       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_FEAT - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        OUT
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [N_FEAT*FEAT_W-1:0]   feat_reg;
    logic [IDX_W-1:0]           idx;
    logic [3:0]                 settle_cnt;
    logic                       frame_err;
    logic                       m_class_r;
    logic                       m_err_r;
    logic                       accept;
    logic                       close_frame;
    logic                       settle_done;
    logic                       result_taken;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake strobes; only LOAD takes beats, only OUT offers results.
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        close_frame  = 1'b0;
        settle_done  = 1'b0;
        result_taken = 1'b0;
        bus.s_ready  = 1'b0;
        bus.m_valid  = 1'b0;
        case (state)
            LOAD: begin
                bus.s_ready = 1'b1;
                accept      = bus.s_valid;
                close_frame = accept && (bus.s_last || (idx == LAST_IDX));
                if (close_frame) begin
                    next_state = EVAL;
                end
            end
            EVAL: begin
                settle_done = (settle_cnt == SETTLE_LAST);
                if (settle_done) begin
                    next_state = OUT;
                end
            end
            OUT: begin
                bus.m_valid  = 1'b1;
                result_taken = bus.m_ready;
                if (result_taken) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    // Frame assembly, settle timing and result capture; a taken result wipes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_reg   <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            frame_err  <= 1'b0;
            m_class_r  <= 1'b0;
            m_err_r    <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N_FEAT; k++) begin
                    if (idx == IDX_W'(k)) begin
                        feat_reg[k*FEAT_W +: FEAT_W] <= bus.s_data;
                    end
                end
                idx <= idx + 1'b1;
            end
            if (close_frame) begin
                frame_err  <= (idx != LAST_IDX) || !bus.s_last;
                settle_cnt <= '0;
            end else if (state == EVAL) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (settle_done) begin
                m_class_r <= core_out;
                m_err_r   <= frame_err;
            end
            if (result_taken) begin
                feat_reg <= '0;
                idx      <= '0;
            end
        end
    end

    // Saturating batch statistics; a clear beats a simultaneous result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count <= '0;
            pos_count    <= '0;
        end else if (cnt_clear) begin
            sample_count <= '0;
            pos_count    <= '0;
        end else if (result_taken) begin
            if (sample_count != '1) begin
                sample_count <= sample_count + 1'b1;
            end
            if (m_class_r && (pos_count != '1)) begin
                pos_count <= pos_count + 1'b1;
            end
        end
    end

    assign core_feat   = feat_reg;
    assign bus.m_class = m_class_r;
    assign bus.m_err   = m_err_r;

endmodule

// File: tb/tb_tnn_frame_sequencer.sv
// Bench for tnn_frame_sequencer: two instances (default parameters, and a
// 3-cycle settle / 2-bit counter variant) driven one at a time through a
// shared stimulus path and checked against a frame-level reference model.
module tb_tnn_frame_sequencer;

    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       sel = 1'b0;
    logic       s_valid = 1'b0;
    logic [1:0] s_data = 2'b00;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b0;
    logic       cnt_clear = 1'b0;
    int         core_mode = 0;
    logic       ov_en = 1'b0;
    logic       ov_val = 1'b0;

    logic [FW-1:0] feat_a, feat_b;
    logic          core_out_a, core_out_b;
    logic [15:0]   cnt_s_a, cnt_p_a;
    logic [1:0]    cnt_s_b, cnt_p_b;

    logic        obs_s_ready, obs_m_valid, obs_m_class, obs_m_err;
    logic [31:0] obs_feat, obs_samples, obs_pos;

    int checks = 0;
    int errors = 0;
    int exp_samples[2];
    int exp_pos[2];
    int cnt_max[2] = '{65535, 3};
    int eval_cyc[2] = '{1, 3};

    logic [1:0] beats[8];
    int         nbeats;
    logic       with_last;

    tnn_frame_sequencer_if #(.FEAT_W(2)) bus_a ();
    tnn_frame_sequencer_if #(.FEAT_W(2)) bus_b ();

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference classifier: the behaviour the core model presents on core_out.
    function automatic logic core_fn(input int mode, input logic [FW-1:0] f);
        case (mode)
            0:       return f[1];
            1:       return 1'b1;
            default: return ^f;
        endcase
    endfunction

    assign bus_a.s_valid = s_valid & ~sel;
    assign bus_a.s_data  = s_data;
    assign bus_a.s_last  = s_last;
    assign bus_a.m_ready = m_ready & ~sel;
    assign bus_b.s_valid = s_valid & sel;
    assign bus_b.s_data  = s_data;
    assign bus_b.s_last  = s_last;
    assign bus_b.m_ready = m_ready & sel;

    assign core_out_a = ov_en ? ov_val : core_fn(core_mode, feat_a);
    assign core_out_b = ov_en ? ov_val : core_fn(core_mode, feat_b);

    tnn_frame_sequencer #(.N_FEAT(8), .FEAT_W(2), .EVAL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_a),
        .core_feat    (feat_a),
        .core_out     (core_out_a),
        .cnt_clear    (cnt_clear & ~sel),
        .sample_count (cnt_s_a),
        .pos_count    (cnt_p_a)
    );

    tnn_frame_sequencer #(.N_FEAT(8), .FEAT_W(2), .EVAL_CYCLES(3), .CNT_W(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_b),
        .core_feat    (feat_b),
        .core_out     (core_out_b),
        .cnt_clear    (cnt_clear & sel),
        .sample_count (cnt_s_b),
        .pos_count    (cnt_p_b)
    );

    // Present the selected instance's outputs on one observation path.
    always_comb begin
        obs_s_ready = sel ? bus_b.s_ready : bus_a.s_ready;
        obs_m_valid = sel ? bus_b.m_valid : bus_a.m_valid;
        obs_m_class = sel ? bus_b.m_class : bus_a.m_class;
        obs_m_err   = sel ? bus_b.m_err   : bus_a.m_err;
        obs_feat    = sel ? {16'b0, feat_b} : {16'b0, feat_a};
        obs_samples = sel ? {30'b0, cnt_s_b} : {16'b0, cnt_s_a};
        obs_pos     = sel ? {30'b0, cnt_p_b} : {16'b0, cnt_p_a};
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d): observed=0x%0h expected=0x%0h", tag, sel, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check_output("rst_s_ready", {31'b0, obs_s_ready}, 1);
        check_output("rst_m_valid", {31'b0, obs_m_valid}, 0);
        check_output("rst_m_class", {31'b0, obs_m_class}, 0);
        check_output("rst_m_err", {31'b0, obs_m_err}, 0);
        check_output("rst_core_feat", obs_feat, 0);
        check_output("rst_samples", obs_samples, 0);
        check_output("rst_pos", obs_pos, 0);
    endtask

    task automatic gen_frame();
        nbeats    = $urandom_range(8, 1);
        with_last = (nbeats < 8) ? 1'b1 : 1'(($urandom_range(1, 0)));
        for (int k = 0; k < 8; k++) begin
            beats[k] = 2'($urandom);
        end
    endtask

    // Send the frame held in beats/nbeats/with_last, then take its result.
    task automatic run_frame(input int gap_max, input int hold, input logic clear_on_take);
        logic [FW-1:0] exp_feat;
        logic          exp_err;
        logic          exp_class;
        int            wait_cyc;
        exp_feat = '0;
        exp_err  = !((nbeats == 8) && with_last);
        for (int k = 0; k < nbeats; k++) begin
            exp_feat[2*k +: 2] = beats[k];
            repeat ($urandom_range(gap_max, 0)) tick();
            s_valid = 1'b1;
            s_data  = beats[k];
            s_last  = with_last && (k == nbeats - 1);
            check_output("s_ready_load", {31'b0, obs_s_ready}, 1);
            tick();
            s_valid = 1'b0;
            s_data  = 2'($urandom);
            s_last  = 1'($urandom);
        end
        check_output("core_feat", obs_feat, {16'b0, exp_feat});
        exp_class = core_fn(core_mode, exp_feat);
        wait_cyc  = 0;
        while (!obs_m_valid && wait_cyc < 40) begin
            check_output("s_ready_eval", {31'b0, obs_s_ready}, 0);
            check_output("feat_held", obs_feat, {16'b0, exp_feat});
            if (ov_en) begin
                ov_val    = 1'($urandom);
                exp_class = ov_val;
            end
            tick();
            wait_cyc++;
        end
        check_output("latency", wait_cyc, eval_cyc[sel]);
        for (int c = 0; c < hold; c++) begin
            if (ov_en) ov_val = ~ov_val;
            check_output("hold_m_valid", {31'b0, obs_m_valid}, 1);
            check_output("hold_m_class", {31'b0, obs_m_class}, {31'b0, exp_class});
            check_output("hold_s_ready", {31'b0, obs_s_ready}, 0);
            tick();
        end
        check_output("m_class", {31'b0, obs_m_class}, {31'b0, exp_class});
        check_output("m_err", {31'b0, obs_m_err}, {31'b0, exp_err});
        m_ready   = 1'b1;
        cnt_clear = clear_on_take;
        tick();
        m_ready   = 1'b0;
        cnt_clear = 1'b0;
        if (clear_on_take) begin
            exp_samples[sel] = 0;
            exp_pos[sel]     = 0;
        end else begin
            if (exp_samples[sel] < cnt_max[sel]) exp_samples[sel]++;
            if (exp_class && exp_pos[sel] < cnt_max[sel]) exp_pos[sel]++;
        end
        ov_en = 1'b0;
        check_output("m_valid_drop", {31'b0, obs_m_valid}, 0);
        check_output("feat_cleared", obs_feat, 0);
        check_output("s_ready_back", {31'b0, obs_s_ready}, 1);
        check_output("sample_count", obs_samples, exp_samples[sel]);
        check_output("pos_count", obs_pos, exp_pos[sel]);
    endtask

    task automatic apply_stimulus();
        // Reset state of both instances.
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            #1;
            check_reset_state();
        end
        sel = 1'b0;
        rst_n = 1'b1;
        exp_samples = '{0, 0};
        exp_pos     = '{0, 0};
        tick();

        // Nominal frame.
        core_mode = 0;
        beats = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        nbeats = 8; with_last = 1'b1;
        run_frame(0, 0, 1'b0);

        // Early s_last after three beats.
        beats = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        nbeats = 3; with_last = 1'b1;
        run_frame(0, 0, 1'b0);

        // Eight beats without s_last, then a frame right behind it.
        gen_frame(); nbeats = 8; with_last = 1'b0;
        run_frame(0, 0, 1'b0);
        gen_frame();
        run_frame(1, 0, 1'b0);

        // Backpressure, then a following frame.
        gen_frame();
        run_frame(0, 10, 1'b0);
        gen_frame();
        run_frame(0, 0, 1'b0);

        // Saturation and clear on the 2-bit counter instance.
        sel = 1'b1;
        core_mode = 1;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        exp_samples[1] = 0;
        exp_pos[1]     = 0;
        check_output("clear_samples", obs_samples, 0);
        for (int f = 0; f < 5; f++) begin
            gen_frame();
            run_frame(1, 0, 1'b0);
        end
        gen_frame();
        run_frame(0, 0, 1'b1);

        // Settle-window sampling on the 3-cycle instance.
        core_mode = 0;
        for (int f = 0; f < 3; f++) begin
            gen_frame();
            ov_en = 1'b1;
            run_frame(0, 2, 1'b0);
        end

        // Randomized frames on both instances.
        for (int f = 0; f < 40; f++) begin
            sel       = 1'($urandom);
            core_mode = $urandom_range(2, 0);
            gen_frame();
            ov_en = 1'($urandom);
            run_frame(2, $urandom_range(3, 0), ($urandom_range(9, 0) == 0));
        end

        // Reset in the middle of a frame.
        sel = 1'b0;
        core_mode = 0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = 2'd2;
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_samples = '{0, 0};
        exp_pos     = '{0, 0};
        check_reset_state();
        tick();
        rst_n = 1'b1;
        tick();
        beats = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        nbeats = 8; with_last = 1'b1;
        run_frame(0, 0, 1'b0);
        check_output("after_rst_feat_prev", {31'b0, obs_m_valid}, 0);
    endtask

    initial begin
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
